// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: hands the single RTC bus controller to one requester at a time
// (ini, hora, fecha, timer, periodic background read "lectura") and drives the
// matching one-hot grant plus the bus mux select. Owners change only after the
// controller has gone idle (DRAIN state).
// Optional build macro: RTC_ARB_WATCHDOG_EN adds a grant-hold watchdog that
// force-releases a grant after TIMEOUT_CYCLES cycles and raises sticky wd_err.
module rtc_bus_arbiter #(
   parameter int REFRESH_CYCLES = 100000,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ini_req,
   input  logic       hora_req,
   input  logic       fecha_req,
   input  logic       timer_req,
   input  logic       rd_done,
   input  logic       rtc_work,
   output logic       gnt_ini,
   output logic       gnt_hora,
   output logic       gnt_fecha,
   output logic       gnt_timer,
   output logic       gnt_lectura,
   output logic [2:0] sel,
   output logic       rd_start,
   output logic       init_ok,
   output logic       busy,
   output logic       wd_err
);

   localparam logic [2:0] SEL_NONE  = 3'd0;
   localparam logic [2:0] SEL_INI   = 3'd1;
   localparam logic [2:0] SEL_HORA  = 3'd2;
   localparam logic [2:0] SEL_FECHA = 3'd3;
   localparam logic [2:0] SEL_TIMER = 3'd4;
   localparam logic [2:0] SEL_LECT  = 3'd5;

   localparam int                RCNT_W    = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
   localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REFRESH_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_DRAIN
   } state_t;

   state_t            state;
   state_t            state_n;
   logic [2:0]        sel_n;
   logic [2:0]        rr;
   logic [2:0]        rr_n;
   logic [2:0]        winner;
   logic              rd_start_n;
   logic              init_ok_n;
   logic              wd_err_n;
   logic              refresh_pending;
   logic              pend_clr;
   logic              refresh_tick;
   logic              owner_rel;
   logic              wd_expire;
   logic [RCNT_W-1:0] rcnt;

   if (REFRESH_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("rtc_bus_arbiter: REFRESH_CYCLES and TIMEOUT_CYCLES must be at least 2");
   end

   assign refresh_tick = init_ok && (rcnt == RCNT_LAST);

   // Background-read period counter; idle until initialization has completed.
   always_ff @(posedge clk) begin
      if (reset) begin
         rcnt            <= '0;
         refresh_pending <= 1'b0;
      end else begin
         if (init_ok) begin
            if (rcnt == RCNT_LAST) rcnt <= '0;
            else                   rcnt <= rcnt + 1'b1;
         end
         // A tick landing on the same edge as the lectura grant survives the clear.
         refresh_pending <= refresh_tick | (refresh_pending & ~pend_clr);
      end
   end

`ifdef RTC_ARB_WATCHDOG_EN
   localparam int              WD_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   logic [WD_W-1:0] wd_cnt;

   // Counts grant cycles of the current owner; cleared whenever no grant is held.
   always_ff @(posedge clk) begin
      if (reset || state != S_GRANT) wd_cnt <= '0;
      else                           wd_cnt <= wd_cnt + 1'b1;
   end

   assign wd_expire = (state == S_GRANT) && (wd_cnt == WD_LAST);
`else
   assign wd_expire = 1'b0;
`endif

   // Priority pick: ini first, then pending background read, then round-robin.
   always_comb begin
      winner = SEL_NONE;
      if (ini_req) begin
         winner = SEL_INI;
      end else if (init_ok) begin
         if (refresh_pending) begin
            winner = SEL_LECT;
         end else begin
            case (rr)
               SEL_HORA: begin
                  if      (hora_req)  winner = SEL_HORA;
                  else if (fecha_req) winner = SEL_FECHA;
                  else if (timer_req) winner = SEL_TIMER;
               end
               SEL_FECHA: begin
                  if      (fecha_req) winner = SEL_FECHA;
                  else if (timer_req) winner = SEL_TIMER;
                  else if (hora_req)  winner = SEL_HORA;
               end
               default: begin
                  if      (timer_req) winner = SEL_TIMER;
                  else if (hora_req)  winner = SEL_HORA;
                  else if (fecha_req) winner = SEL_FECHA;
               end
            endcase
         end
      end
   end

   // The current owner gives the bus back by dropping its request (rd_done for lectura).
   always_comb begin
      owner_rel = 1'b0;
      case (sel)
         SEL_INI:   owner_rel = ~ini_req;
         SEL_HORA:  owner_rel = ~hora_req;
         SEL_FECHA: owner_rel = ~fecha_req;
         SEL_TIMER: owner_rel = ~timer_req;
         SEL_LECT:  owner_rel = rd_done;
         default:   owner_rel = 1'b0;
      endcase
   end

   // Next-state and next-output logic of the IDLE/GRANT/DRAIN controller.
   always_comb begin
      state_n    = state;
      sel_n      = sel;
      rr_n       = rr;
      rd_start_n = 1'b0;
      init_ok_n  = init_ok;
      wd_err_n   = wd_err;
      pend_clr   = 1'b0;
      case (state)
         S_IDLE: begin
            if (winner != SEL_NONE) begin
               state_n = S_GRANT;
               sel_n   = winner;
               if (winner == SEL_LECT) begin
                  rd_start_n = 1'b1;
                  pend_clr   = 1'b1;
               end
               if (winner == SEL_HORA)  rr_n = SEL_FECHA;
               if (winner == SEL_FECHA) rr_n = SEL_TIMER;
               if (winner == SEL_TIMER) rr_n = SEL_HORA;
            end
         end
         S_GRANT: begin
            if (owner_rel || wd_expire) begin
               state_n = S_DRAIN;
               sel_n   = SEL_NONE;
               if (sel == SEL_INI) init_ok_n = 1'b1;
               if (wd_expire)      wd_err_n  = 1'b1;
            end
         end
         S_DRAIN: begin
            if (!rtc_work) state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
            sel_n   = SEL_NONE;
         end
      endcase
   end

   // State and registered outputs; grants are decoded from the next select value.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         sel         <= SEL_NONE;
         rr          <= SEL_HORA;
         gnt_ini     <= 1'b0;
         gnt_hora    <= 1'b0;
         gnt_fecha   <= 1'b0;
         gnt_timer   <= 1'b0;
         gnt_lectura <= 1'b0;
         rd_start    <= 1'b0;
         init_ok     <= 1'b0;
         busy        <= 1'b0;
         wd_err      <= 1'b0;
      end else begin
         state       <= state_n;
         sel         <= sel_n;
         rr          <= rr_n;
         gnt_ini     <= (sel_n == SEL_INI);
         gnt_hora    <= (sel_n == SEL_HORA);
         gnt_fecha   <= (sel_n == SEL_FECHA);
         gnt_timer   <= (sel_n == SEL_TIMER);
         gnt_lectura <= (sel_n == SEL_LECT);
         rd_start    <= rd_start_n;
         init_ok     <= init_ok_n;
         busy        <= (state_n != S_IDLE);
         wd_err      <= wd_err_n;
      end
   end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// tb_rtc_bus_arbiter: directed scenarios plus randomized traffic for rtc_bus_arbiter,
// every cycle compared against a transaction-level model of the arbitration rules.
module tb_rtc_bus_arbiter;

   localparam int REFRESH = 50;
   localparam int TIMEOUT = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       ini_req, hora_req, fecha_req, timer_req, rd_done, rtc_work;
   logic       gnt_ini, gnt_hora, gnt_fecha, gnt_timer, gnt_lectura;
   logic [2:0] sel;
   logic       rd_start, init_ok, busy, wd_err;
   logic [11:0] dut_outs;

   int checks   = 0;
   int failures = 0;

   // Model state: owner code (0 none, 1 ini .. 5 lectura), drain flag, flags and counters.
   int m_owner, m_rcnt, m_rr, m_held;
   bit m_drain, m_init_ok, m_pend, m_wd_err, m_rd_start;

   int order[$];

   always #5 clk = ~clk;

   assign dut_outs = {gnt_ini, gnt_hora, gnt_fecha, gnt_timer, gnt_lectura,
                      sel, rd_start, init_ok, busy, wd_err};

   rtc_bus_arbiter #(
      .REFRESH_CYCLES(REFRESH),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ini_req    (ini_req),
      .hora_req   (hora_req),
      .fecha_req  (fecha_req),
      .timer_req  (timer_req),
      .rd_done    (rd_done),
      .rtc_work   (rtc_work),
      .gnt_ini    (gnt_ini),
      .gnt_hora   (gnt_hora),
      .gnt_fecha  (gnt_fecha),
      .gnt_timer  (gnt_timer),
      .gnt_lectura(gnt_lectura),
      .sel        (sel),
      .rd_start   (rd_start),
      .init_ok    (init_ok),
      .busy       (busy),
      .wd_err     (wd_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = 0; m_drain = 0; m_init_ok = 0; m_pend = 0; m_rcnt = 0;
      m_rr = 2; m_held = 0; m_wd_err = 0; m_rd_start = 0;
   endtask

   function automatic int model_winner();
      bit want [2:4];
      if (ini_req) return 1;
      if (!m_init_ok) return 0;
      if (m_pend) return 5;
      want[2] = hora_req;
      want[3] = fecha_req;
      want[4] = timer_req;
      for (int k = 0; k < 3; k++) begin
         int c;
         c = 2 + ((m_rr - 2 + k) % 3);
         if (want[c]) return c;
      end
      return 0;
   endfunction

   // Advance the model by one clock using the inputs presented before the edge.
   task automatic model_clock();
      int n_owner, n_rcnt, w;
      bit n_drain, n_init, tick, clr, rel;
      if (reset) begin
         model_reset();
         return;
      end
      n_owner = m_owner; n_drain = m_drain; n_init = m_init_ok; n_rcnt = m_rcnt;
      tick = 0; clr = 0; rel = 0; m_rd_start = 0;
      if (m_init_ok) begin
         n_rcnt = (m_rcnt + 1) % REFRESH;
         tick   = (n_rcnt == 0);
      end
      if (m_owner != 0) begin
         m_held++;
         case (m_owner)
            1:       rel = !ini_req;
            2:       rel = !hora_req;
            3:       rel = !fecha_req;
            4:       rel = !timer_req;
            default: rel = rd_done;
         endcase
`ifdef RTC_ARB_WATCHDOG_EN
         if (m_held >= TIMEOUT) begin
            rel      = 1;
            m_wd_err = 1;
         end
`endif
         if (rel) begin
            if (m_owner == 1) n_init = 1;
            n_owner = 0;
            n_drain = 1;
         end
      end else if (m_drain) begin
         if (!rtc_work) n_drain = 0;
      end else begin
         w = model_winner();
         if (w != 0) begin
            n_owner = w;
            m_held  = 0;
            if (w == 5) begin
               clr        = 1;
               m_rd_start = 1;
            end
            if (w >= 2 && w <= 4) m_rr = (w == 4) ? 2 : w + 1;
         end
      end
      m_pend    = tick || (m_pend && !clr);
      m_owner   = n_owner;
      m_drain   = n_drain;
      m_init_ok = n_init;
      m_rcnt    = n_rcnt;
   endtask

   function automatic logic [31:0] model_outs();
      logic [11:0] v;
      v = {m_owner == 1, m_owner == 2, m_owner == 3, m_owner == 4, m_owner == 5,
           3'(m_owner), m_rd_start, m_init_ok, (m_owner != 0) || m_drain, m_wd_err};
      return 32'(v);
   endfunction

   task automatic step();
      model_clock();
      @(posedge clk);
      #1;
      chk("outs", 32'(dut_outs), model_outs());
   endtask

   task automatic clear_inputs();
      ini_req = 0; hora_req = 0; fecha_req = 0; timer_req = 0; rd_done = 0; rtc_work = 0;
   endtask

   // Reset, then run one ini grant that drops immediately; returns on the DRAIN-entry cycle.
   task automatic do_init();
      reset = 1; clear_inputs();
      step(); step();
      reset = 0; step();
      ini_req = 1; step();
      ini_req = 0; step();
   endtask

   task automatic measure_gap(input int work_cycles, output int gap);
      int n;
      do_init();
      hora_req = 1; fecha_req = 1;
      n = 0;
      while (!gnt_hora && n < 20) begin
         step();
         n++;
      end
      chk("t3_hora_grant", 32'(gnt_hora), 1);
      step();
      hora_req = 0;
      gap = 0;
      for (int i = 0; i < 40; i++) begin
         rtc_work = (i >= 1 && i <= work_cycles);
         step();
         gap++;
         if (gnt_fecha) break;
      end
      rtc_work = 0; fecha_req = 0;
      repeat (4) step();
   endtask

   initial begin
      int held, g0, g5, run, lect, n;
      bit prev, dropped;
      int exp_order [4] = '{2, 3, 4, 2};

      model_reset();
      reset = 1; clear_inputs();

      // Reset state and ini-only eligibility before initialization.
      step();
      chk("rst_outs", 32'(dut_outs), 32'h0);
      reset = 0; step();
      ini_req = 1; hora_req = 1; step();
      chk("t1_gnt_ini", 32'(gnt_ini), 1);
      chk("t1_sel_ini", 32'(sel), 1);
      chk("t1_no_hora", 32'(gnt_hora), 0);
      repeat (3) step();
      chk("t1_hora_held_off", 32'(gnt_hora), 0);
      chk("t1_init_pre", 32'(init_ok), 0);
      ini_req = 0; step();
      chk("t1_init_ok", 32'(init_ok), 1);
      chk("t1_ini_off", 32'(gnt_ini), 0);
      step();
      chk("t1_idle_gap", 32'(gnt_hora), 0);
      step();
      chk("t1_gnt_hora", 32'(gnt_hora), 1);
      chk("t1_sel_hora", 32'(sel), 2);
      hora_req = 0; repeat (3) step();

      // Round-robin among hora/fecha/timer, each owner holding four cycles.
      do_init();
      hora_req = 1; fecha_req = 1; timer_req = 1;
      held = 0;
      order.delete();
      for (int cyc = 0; cyc < 60 && order.size() < 4; cyc++) begin
         step();
         if (sel != 3'd0) begin
            held++;
            if (held == 1) order.push_back(int'(sel));
            if (held == 4) begin
               if (sel == 3'd2) hora_req  = 0;
               if (sel == 3'd3) fecha_req = 0;
               if (sel == 3'd4) timer_req = 0;
            end
         end else begin
            held = 0;
            hora_req = 1; fecha_req = 1; timer_req = 1;
         end
      end
      chk("t2_count", order.size(), 4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("t2_order%0d", i), (i < order.size()) ? order[i] : 0, exp_order[i]);
      hora_req = 0; fecha_req = 0; timer_req = 0;
      repeat (4) step();

      // rtc_work held high in DRAIN stretches the hand-over cycle for cycle.
      measure_gap(0, g0);
      measure_gap(5, g5);
      chk("t3_gap0", g0, 3);
      chk("t3_gap5_delta", g5 - g0, 5);

      // Background read wins over fecha once the refresh period elapses.
      do_init();
      for (int i = 1; i <= REFRESH; i++) step();
      chk("t4_not_early", 32'(gnt_lectura), 0);
      fecha_req = 1; step();
      chk("t4_gnt_lect", 32'(gnt_lectura), 1);
      chk("t4_sel_lect", 32'(sel), 5);
      chk("t4_rd_start", 32'(rd_start), 1);
      chk("t4_no_fecha", 32'(gnt_fecha), 0);
      step();
      chk("t4_rd_start_pulse", 32'(rd_start), 0);
      chk("t4_lect_hold", 32'(gnt_lectura), 1);
      rd_done = 1; step();
      rd_done = 0;
      chk("t4_lect_off", 32'(gnt_lectura), 0);
      step(); step();
      chk("t4_gnt_fecha", 32'(gnt_fecha), 1);
      chk("t4_sel_fecha", 32'(sel), 3);
      fecha_req = 0; repeat (3) step();

      // Two wraps while ini holds the bus collapse into a single lectura grant.
      do_init();
      ini_req = 1;
      repeat (110) step();
      chk("t5_ini_held", 32'(gnt_ini), 1);
      ini_req = 0;
      lect = 0; prev = 0;
      for (int i = 0; i < 33; i++) begin
         step();
         if (gnt_lectura && !prev) lect++;
         prev    = gnt_lectura;
         rd_done = gnt_lectura;
      end
      rd_done = 0;
      chk("t5_single_lect", lect, 1);

      // Long-held timer grant: watchdog release when built in, indefinite hold otherwise.
      do_init();
      timer_req = 1;
      run = 0; dropped = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (gnt_timer && !dropped) run++;
         if (!gnt_timer && run > 0) dropped = 1;
      end
`ifdef RTC_ARB_WATCHDOG_EN
      chk("t6_run", run, TIMEOUT);
      chk("t6_wd_err", 32'(wd_err), 1);
      timer_req = 0; repeat (6) step();
      chk("t6_wd_sticky", 32'(wd_err), 1);
`else
      chk("t6_run", run, 39);
      chk("t6_still_gnt", 32'(gnt_timer), 1);
      chk("t6_wd_err", 32'(wd_err), 0);
      timer_req = 0; repeat (6) step();
`endif

      // Randomized traffic with occasional resets, checked cycle by cycle.
      reset = 1; clear_inputs(); step();
      reset = 0;
      n = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) ini_req   = ~ini_req;
         if ($urandom_range(0, 5) == 0) hora_req  = ~hora_req;
         if ($urandom_range(0, 5) == 0) fecha_req = ~fecha_req;
         if ($urandom_range(0, 5) == 0) timer_req = ~timer_req;
         rd_done  = ($urandom_range(0, 5) == 0);
         rtc_work = ($urandom_range(0, 2) == 0);
         reset    = ($urandom_range(0, 399) == 0);
         step();
         if (gnt_lectura) n++;
      end
      reset = 0; clear_inputs(); step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
